// File: rtl/pstore_seq_ctrl.sv
// pstore_seq_ctrl
//  Sequencer for the layer-1 partial-sum accumulator bank. A start pulse clears the
//  bank for one cycle. The controller then gates one accumulate per accepted input
//  word until NUM_INPUTS words have been taken. It waits DRAIN_CYCLES cycles and then
//  holds out_valid until out_ready takes the sums.
//
//  Optional feature macro: PSTORE_SEQ_ABORT_EN adds an abort input. Abort returns the
//  controller to IDLE from any busy state and clears the bank on the way out.
//
//  Ports
//   clk        in   system clock, rising edge
//   clr        in   asynchronous reset, active-low
//   start      in   begin an inference (IDLE, or DONE handshake cycle)
//   in_valid   in   input word present on the bank inputs
//   in_ready   out  controller accepts a word this cycle
//   acc_en     out  bank clock-enable, in_valid & in_ready (combinational)
//   acc_clr    out  bank clear, active-high
//   pixel_idx  out  index of the next expected word (weight fetch address)
//   busy       out  high in every state except IDLE
//   out_valid  out  bank holds final sums
//   out_ready  in   downstream has taken the sums
//   abort      in   (PSTORE_SEQ_ABORT_EN only) abandon the current inference

module pstore_seq_ctrl #(
  parameter int unsigned NUM_INPUTS   = 784,
  parameter int unsigned IDX_W        = 10,
  parameter int unsigned DRAIN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             acc_en,
  output logic             acc_clr,
  output logic [IDX_W-1:0] pixel_idx,
  output logic             busy,
  output logic             out_valid,
`ifdef PSTORE_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             out_ready
);

  localparam int unsigned      CNT_W      = 4;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_INPUTS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD =
    CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [CNT_W-1:0] drain_cnt, drain_cnt_nxt;
  logic             abort_take;
  logic             in_ready_nxt, acc_clr_nxt, busy_nxt, out_valid_nxt;

  // in_ready is only high in ACCUM, so a clear cycle can never carry an accumulate.
  assign acc_en = in_valid & in_ready;

`ifdef PSTORE_SEQ_ABORT_EN
  // Abort in IDLE has nothing to abandon.
  assign abort_take = abort & (state != S_IDLE);
`else
  assign abort_take = 1'b0;
`endif

  // Next-state, index, drain counter and next values of the registered outputs.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = pixel_idx;
    drain_cnt_nxt = drain_cnt;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        idx_nxt   = '0;
        state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        if (acc_en) begin
          if (pixel_idx == LAST_IDX) begin
            idx_nxt = '0;
            if (DRAIN_CYCLES == 0) begin
              state_nxt = S_DONE;
            end else begin
              state_nxt     = S_DRAIN;
              drain_cnt_nxt = DRAIN_LOAD;
            end
          end else begin
            idx_nxt = pixel_idx + IDX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // Counter is loaded with DRAIN_CYCLES-1 so DRAIN lasts exactly DRAIN_CYCLES cycles.
        if (drain_cnt == '0) state_nxt = S_DONE;
        else                 drain_cnt_nxt = drain_cnt - CNT_W'(1);
      end
      S_DONE: begin
        // out_valid is always high here, so out_ready alone completes the handshake.
        if (out_ready) state_nxt = start ? S_CLEAR : S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides every other event, including start and the DONE handshake.
    if (abort_take) begin
      state_nxt     = S_IDLE;
      idx_nxt       = '0;
      drain_cnt_nxt = '0;
    end

    in_ready_nxt  = (state_nxt == S_ACCUM);
    acc_clr_nxt   = (state_nxt == S_CLEAR) | abort_take;
    busy_nxt      = (state_nxt != S_IDLE);
    out_valid_nxt = (state_nxt == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= S_IDLE;
      pixel_idx <= '0;
      drain_cnt <= '0;
      in_ready  <= 1'b0;
      acc_clr   <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      pixel_idx <= idx_nxt;
      drain_cnt <= drain_cnt_nxt;
      in_ready  <= in_ready_nxt;
      acc_clr   <= acc_clr_nxt;
      busy      <= busy_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_pstore_seq_ctrl.sv
// Testbench for pstore_seq_ctrl.
// dut0: NUM_INPUTS=4, DRAIN_CYCLES=1. dut1: NUM_INPUTS=1, DRAIN_CYCLES=0.
// Each cycle's outputs are packed as {in_ready, acc_en, acc_clr, busy, out_valid, pixel_idx}.
// Cycle c spans posedge c to posedge c+1. Inputs change 1 ns after the edge.
// Outputs are checked 3 ns after the edge.
`timescale 1ns/1ps
module tb_pstore_seq_ctrl;

  localparam int unsigned N0 = 4, W0 = 3, D0 = 1;
  localparam int unsigned N1 = 1, W1 = 1, D1 = 0;

  logic clk = 1'b0;
  logic clr;
  logic start, in_valid, out_ready, in_ready, acc_en, acc_clr, busy, out_valid;
  logic [W0-1:0] pixel_idx;
  logic start1, in_valid1, out_ready1, in_ready1, acc_en1, acc_clr1, busy1, out_valid1;
  logic [W1-1:0] pixel_idx1;
`ifdef PSTORE_SEQ_ABORT_EN
  logic abort, abort1;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int pulse_cnt   = 0;

  wire [7:0] obs0 = {in_ready, acc_en, acc_clr, busy, out_valid, pixel_idx};
  wire [5:0] obs1 = {in_ready1, acc_en1, acc_clr1, busy1, out_valid1, pixel_idx1};

  pstore_seq_ctrl #(.NUM_INPUTS(N0), .IDX_W(W0), .DRAIN_CYCLES(D0)) dut0 (
    .clk(clk), .clr(clr), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .acc_en(acc_en), .acc_clr(acc_clr), .pixel_idx(pixel_idx), .busy(busy),
    .out_valid(out_valid),
`ifdef PSTORE_SEQ_ABORT_EN
    .abort(abort),
`endif
    .out_ready(out_ready)
  );

  pstore_seq_ctrl #(.NUM_INPUTS(N1), .IDX_W(W1), .DRAIN_CYCLES(D1)) dut1 (
    .clk(clk), .clr(clr), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
    .acc_en(acc_en1), .acc_clr(acc_clr1), .pixel_idx(pixel_idx1), .busy(busy1),
    .out_valid(out_valid1),
`ifdef PSTORE_SEQ_ABORT_EN
    .abort(abort1),
`endif
    .out_ready(out_ready1)
  );

  always #5 clk = ~clk;

  // Independent tally of accumulate pulses on dut0.
  always @(negedge clk) if (acc_en) pulse_cnt = pulse_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    start1 = 1'b1; in_valid1 = 1'b1; out_ready1 = 1'b1;
    tick(); tick();
    #2;
    vectors++;
    if (obs0 !== 8'd0) begin
      miscompares++; $display("FAIL reset0: got %b want %b", obs0, 8'd0);
    end
    vectors++;
    if (obs1 !== 6'd0) begin
      miscompares++; $display("FAIL reset1: got %b want %b", obs1, 6'd0);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    start1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    clr = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic ir, ae, ac, bz, ov; logic [2:0] ix; logic [7:0] e;
    for (int c = 0; c <= 10; c++) begin
      start = (c == 0); in_valid = 1'b1; out_ready = (c == 9);
      #2;
      ir = (c >= 2 && c <= 5); ae = ir; ac = (c == 1);
      bz = (c >= 1 && c <= 9); ov = (c >= 7 && c <= 9);
      ix = ir ? 3'(c - 2) : 3'd0;
      e = {ir, ae, ac, bz, ov, ix};
      vectors++;
      if (obs0 !== e) begin
        miscompares++; $display("FAIL basic c%0d: got %b want %b", c, obs0, e);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic ir, ae, ac, bz, ov; logic [2:0] ix; logic [7:0] e;
    for (int c = 0; c <= 11; c++) begin
      start = (c == 0); in_valid = !(c == 3 || c == 4); out_ready = (c == 10);
      #2;
      ir = (c >= 2 && c <= 7); ae = ir && !(c == 3 || c == 4); ac = (c == 1);
      bz = (c >= 1 && c <= 10); ov = (c >= 9 && c <= 10);
      ix = (c >= 3 && c <= 5) ? 3'd1 : (c == 6) ? 3'd2 : (c == 7) ? 3'd3 : 3'd0;
      e = {ir, ae, ac, bz, ov, ix};
      vectors++;
      if (obs0 !== e) begin
        miscompares++; $display("FAIL stall c%0d: got %b want %b", c, obs0, e);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic ir, ae, ac, bz, ov; logic [2:0] ix; logic [7:0] e;
    for (int c = 0; c <= 15; c++) begin
      start = (c == 0 || c == 7); in_valid = 1'b1; out_ready = (c == 7 || c == 14);
      #2;
      ir = (c >= 2 && c <= 5) || (c >= 9 && c <= 12); ae = ir;
      ac = (c == 1 || c == 8); bz = (c >= 1 && c <= 14); ov = (c == 7 || c == 14);
      ix = (c >= 2 && c <= 5) ? 3'(c - 2) : (c >= 9 && c <= 12) ? 3'(c - 9) : 3'd0;
      e = {ir, ae, ac, bz, ov, ix};
      vectors++;
      if (obs0 !== e) begin
        miscompares++; $display("FAIL back_to_back c%0d: got %b want %b", c, obs0, e);
      end
      tick();
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic ir, ae, ac, bz, ov; logic [2:0] ix; logic [7:0] e;
    for (int c = 0; c <= 4; c++) begin
      start = (c == 0); in_valid = 1'b1;
      #2;
      ir = (c >= 2); ae = ir; ac = (c == 1); bz = (c >= 1); ov = 1'b0;
      ix = ir ? 3'(c - 2) : 3'd0;
      e = {ir, ae, ac, bz, ov, ix};
      vectors++;
      if (obs0 !== e) begin
        miscompares++; $display("FAIL reset_mid pre c%0d: got %b want %b", c, obs0, e);
      end
      if (c < 4) tick();
    end
    clr = 1'b0;
    #1;
    vectors++;
    if (obs0 !== 8'd0) begin
      miscompares++; $display("FAIL reset_mid async: got %b want %b", obs0, 8'd0);
    end
    tick();
    clr = 1'b1;
    tick();
    for (int c = 0; c <= 8; c++) begin
      start = (c == 0); in_valid = 1'b1; out_ready = (c == 7);
      #2;
      ir = (c >= 2 && c <= 5); ae = ir; ac = (c == 1);
      bz = (c >= 1 && c <= 7); ov = (c == 7);
      ix = ir ? 3'(c - 2) : 3'd0;
      e = {ir, ae, ac, bz, ov, ix};
      vectors++;
      if (obs0 !== e) begin
        miscompares++; $display("FAIL reset_mid post c%0d: got %b want %b", c, obs0, e);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  // Reference: an inference is one clear cycle, then ACCUM until N0 words are taken
  // (index = words taken so far), then D0 drain cycles, then DONE until out_ready.
  // start and out_ready are randomised outside the cycles where they count.
  task automatic test_random(input int iters);
    bit b2b = 1'b0; int acc; int p0; logic iv; logic [7:0] e;
    for (int it = 0; it < iters; it++) begin
      p0 = pulse_cnt;
      if (!b2b) begin
        start = 1'b1; in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
        #2;
        e = 8'd0;
        vectors++;
        if (obs0 !== e) begin
          miscompares++; $display("FAIL rnd_idle it%0d: got %b want %b", it, obs0, e);
        end
        tick();
      end
      start = 1'($urandom_range(0, 1)); in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      #2;
      e = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
      vectors++;
      if (obs0 !== e) begin
        miscompares++; $display("FAIL rnd_clear it%0d: got %b want %b", it, obs0, e);
      end
      tick();
      acc = 0;
      while (acc < int'(N0)) begin
        iv = ($urandom_range(0, 2) != 0);
        in_valid = iv; start = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
        #2;
        e = {1'b1, iv, 1'b0, 1'b1, 1'b0, 3'(acc)};
        vectors++;
        if (obs0 !== e) begin
          miscompares++; $display("FAIL rnd_accum it%0d n%0d: got %b want %b", it, acc, obs0, e);
        end
        if (iv) acc++;
        tick();
      end
      for (int d = 0; d < int'(D0); d++) begin
        in_valid = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        #2;
        e = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        vectors++;
        if (obs0 !== e) begin
          miscompares++; $display("FAIL rnd_drain it%0d: got %b want %b", it, obs0, e);
        end
        tick();
      end
      for (int k = int'($urandom_range(0, 3)); k > 0; k--) begin
        in_valid = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1)); out_ready = 1'b0;
        #2;
        e = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
        vectors++;
        if (obs0 !== e) begin
          miscompares++; $display("FAIL rnd_done_hold it%0d: got %b want %b", it, obs0, e);
        end
        tick();
      end
      b2b = (it != iters - 1) && ($urandom_range(0, 1) != 0);
      start = b2b; out_ready = 1'b1; in_valid = 1'($urandom_range(0, 1));
      #2;
      e = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
      vectors++;
      if (obs0 !== e) begin
        miscompares++; $display("FAIL rnd_handshake it%0d: got %b want %b", it, obs0, e);
      end
      tick();
      start = 1'b0; out_ready = 1'b0;
      vectors++;
      if (pulse_cnt - p0 !== int'(N0)) begin
        miscompares++; $display("FAIL rnd_pulses it%0d: got %0d want %0d", it, pulse_cnt - p0, N0);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_single_input();
    logic ir, ae, ac, bz, ov; logic [5:0] e;
    for (int c = 0; c <= 4; c++) begin
      start1 = (c == 0); in_valid1 = (c == 2); out_ready1 = (c == 3);
      #2;
      ir = (c == 2); ae = ir; ac = (c == 1); bz = (c >= 1 && c <= 3); ov = (c == 3);
      e = {ir, ae, ac, bz, ov, 1'b0};
      vectors++;
      if (obs1 !== e) begin
        miscompares++; $display("FAIL single c%0d: got %b want %b", c, obs1, e);
      end
      tick();
    end
    // start during ACCUM must not restart or queue.
    for (int c = 0; c <= 5; c++) begin
      start1 = (c == 0 || c == 2 || c == 3); in_valid1 = (c == 3); out_ready1 = (c == 4);
      #2;
      ir = (c == 2 || c == 3); ae = (c == 3); ac = (c == 1);
      bz = (c >= 1 && c <= 4); ov = (c == 4);
      e = {ir, ae, ac, bz, ov, 1'b0};
      vectors++;
      if (obs1 !== e) begin
        miscompares++; $display("FAIL single_ignore c%0d: got %b want %b", c, obs1, e);
      end
      tick();
    end
    start1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
  endtask

`ifdef PSTORE_SEQ_ABORT_EN
  task automatic test_abort();
    logic ir, ae, ac, bz; logic [2:0] ix; logic [7:0] e;
    for (int c = 0; c <= 9; c++) begin
      start = (c == 0); in_valid = 1'b1; abort = (c == 6); out_ready = 1'b1;
      #2;
      ir = (c >= 2 && c <= 5); ae = ir; ac = (c == 1 || c == 7); bz = (c >= 1 && c <= 6);
      ix = ir ? 3'(c - 2) : 3'd0;
      e = {ir, ae, ac, bz, 1'b0, ix};
      vectors++;
      if (obs0 !== e) begin
        miscompares++; $display("FAIL abort c%0d: got %b want %b", c, obs0, e);
      end
      tick();
    end
    abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask
`endif

  initial begin
`ifdef PSTORE_SEQ_ABORT_EN
    abort = 1'b0; abort1 = 1'b0;
`endif
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random(25);
    test_single_input();
`ifdef PSTORE_SEQ_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
